// File: rtl/store_pkg.sv
// Shared definitions for the program/data store: boot image table and FSM states.
package store_pkg;

    localparam int BOOT_LEN = 32;

    // Boot image, one 8-bit word per address; resized to the store width on load.
    localparam logic [7:0] BOOT_IMAGE [0:BOOT_LEN-1] = '{
        8'h80, 8'h3E, 8'h0C, 8'h5A, 8'h1E, 8'h21, 8'h42, 8'h63,
        8'h84, 8'hA5, 8'hC6, 8'hE7, 8'h08, 8'h29, 8'h4A, 8'h6B,
        8'h7C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

endpackage

// File: rtl/store_boot_rom.sv
// Combinational boot image lookup: word address -> image word at the store width.
module store_boot_rom
    import store_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    // 8-bit table entries are zero-extended or truncated to DATA_W.
    function automatic logic [DATA_W-1:0] fit_width(input logic [7:0] b);
        logic [DATA_W+7:0] wide;
        wide = {{DATA_W{1'b0}}, b};
        return wide[DATA_W-1:0];
    endfunction

    // Table lookup; addresses past the end of the table read as zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < BOOT_LEN; i++) begin
            if (int'(addr) == i) begin
                word = fit_width(BOOT_IMAGE[i]);
            end
        end
    end

endmodule

// File: rtl/store_ram_ctrl.sv
// Single-port program/data store with registered read, init sequencer and
// out-of-range address flagging (no aliasing of addresses >= DEPTH).
module store_ram_ctrl
    import store_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int BOOT_EN = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Initialize,
    input  logic              WE,
    input  logic              RE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_IN,
    output logic [DATA_W-1:0] data_Out,
    output logic              rd_valid,
    output logic              Busy,
    output logic              init_done,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt, cnt_d;
    logic                done_d;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];
    logic [DATA_W-1:0]   image_word;
    logic                in_range, accept, init_wr, user_wr, user_rd, mem_we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data_p1;
    logic                vld_p1, err_p1, done_p1;

    generate
        if (BOOT_EN != 0) begin : g_boot
            store_boot_rom #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W)
            ) u_rom (
                .addr(init_cnt),
                .word(image_word)
            );
        end else begin : g_zero
            assign image_word = '0;
        end
    endgenerate

    // Request qualification and the init/user write mux.
    always_comb begin
        in_range = (int'(addr) < DEPTH);
        init_wr  = (state_q == INIT) && !Initialize;
        accept   = (state_q == IDLE) && !Initialize;
        user_wr  = accept && WE && in_range;
        user_rd  = accept && RE && !WE;
        mem_we   = !Reset && (init_wr || user_wr);
        wr_addr  = init_wr ? init_cnt : addr;
        wr_data  = init_wr ? image_word : data_IN;
    end

    // Next state: Initialize (re)starts the pass, the last word returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = init_cnt;
        done_d  = 1'b0;
        if (Initialize) begin
            state_d = INIT;
            cnt_d   = '0;
        end else if (state_q == INIT) begin
            cnt_d = init_cnt + ADDR_W'(1);
            if (int'(init_cnt) == DEPTH - 1) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
        end
    end

    // FSM state, init counter and completion pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            init_cnt <= '0;
            done_p1  <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_cnt <= cnt_d;
            done_p1  <= done_d;
        end
    end

    // Storage array; deliberately not cleared by Reset.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Registered read port with valid and out-of-range strobes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            vld_p1 <= user_rd;
            err_p1 <= accept && (WE || RE) && !in_range;
            if (user_rd) begin
                rd_data_p1 <= in_range ? mem[addr[IDX_W-1:0]] : '0;
            end
        end
    end

    assign data_Out  = rd_data_p1;
    assign rd_valid  = vld_p1;
    assign addr_err  = err_p1;
    assign init_done = done_p1;
    assign Busy      = (state_q == INIT);

endmodule

// File: tb/tb_store_ram_ctrl.sv
// Directed bench for store_ram_ctrl: three configurations driven by one shared stimulus.
module tb_store_ram_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Initialize = 1'b0;
    logic        WE = 1'b0;
    logic        RE = 1'b0;
    logic [4:0]  addr = '0;
    logic [15:0] din = '0;

    logic [7:0]  dout0, dout1;
    logic [15:0] dout2;
    logic        rv0, rv1, rv2, busy0, busy1, busy2;
    logic        done0, done1, done2, err0, err1, err2;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    store_ram_ctrl u0 (
        .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .WE(WE), .RE(RE),
        .addr(addr), .data_IN(din[7:0]), .data_Out(dout0), .rd_valid(rv0),
        .Busy(busy0), .init_done(done0), .addr_err(err0)
    );

    store_ram_ctrl #(.DEPTH(20)) u1 (
        .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .WE(WE), .RE(RE),
        .addr(addr), .data_IN(din[7:0]), .data_Out(dout1), .rd_valid(rv1),
        .Busy(busy1), .init_done(done1), .addr_err(err1)
    );

    store_ram_ctrl #(.DATA_W(16), .BOOT_EN(0)) u2 (
        .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .WE(WE), .RE(RE),
        .addr(addr), .data_IN(din), .data_Out(dout2), .rd_valid(rv2),
        .Busy(busy2), .init_done(done2), .addr_err(err2)
    );

    typedef struct {
        int          sel;
        logic        we;
        logic        re;
        logic [4:0]  a;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int sel, input logic we, input logic re, input logic [4:0] a,
                       input logic [15:0] d, input logic ev, input logic [15:0] ed,
                       input logic ee);
        vec_t v;
        v.sel = sel; v.we = we; v.re = re; v.a = a; v.d = d;
        v.ev = ev; v.ed = ed; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic rd0(input string name, input logic [4:0] a, input logic [7:0] exp);
        RE = 1'b1; addr = a;
        step();
        RE = 1'b0;
        chk({name, "_vld"}, 16'(rv0), 16'd1);
        chk(name, 16'(dout0), 16'(exp));
    endtask

    task automatic do_init(input int restart_at, input logic hold,
                           output int busy_n, output int done_n, output int viol);
        logic restarted;
        int   idle_n;
        restarted = 1'b0; idle_n = 0; busy_n = 0; done_n = 0; viol = 0;
        Initialize = 1'b1; WE = hold; RE = hold; addr = 5'd2; din = 16'h0055;
        step();
        Initialize = 1'b0;
        for (int c = 0; c < 200 && idle_n < 3; c++) begin
            if (busy0) busy_n++; else idle_n++;
            if (done0) done_n++;
            if (rv0 || err0) viol++;
            if (restart_at > 0 && !restarted && busy_n == restart_at + 1) begin
                Initialize = 1'b1;
                restarted  = 1'b1;
            end else begin
                Initialize = 1'b0;
            end
            WE = hold && busy0;
            RE = hold && busy0;
            step();
        end
        Initialize = 1'b0; WE = 1'b0; RE = 1'b0;
    endtask

    initial begin
        int          bn, dn, vn;
        logic        a_rv, a_err;
        logic [15:0] a_d;

        // Reset state across all three configurations.
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        chk("rst_dout0", 16'(dout0), 16'h0);
        chk("rst_rv0", 16'(rv0), 16'h0);
        chk("rst_busy_all", 16'({busy0, busy1, busy2}), 16'h0);
        chk("rst_done_all", 16'({done0, done1, done2}), 16'h0);
        chk("rst_err_all", 16'({err0, err1, err2}), 16'h0);
        chk("rst_rv12", 16'({rv1, rv2}), 16'h0);
        chk("rst_dout2", dout2, 16'h0);

        // Full init pass.
        do_init(0, 1'b0, bn, dn, vn);
        chk("init_busy_cycles", 16'(bn), 16'd32);
        chk("init_done_pulses", 16'(dn), 16'd1);
        chk("init_no_strobes", 16'(vn), 16'd0);

        // Directed single-cycle vectors.
        add(0, 0, 1, 5'd0,  16'h0000, 1, 16'h0080, 0);
        add(0, 0, 1, 5'd1,  16'h0000, 1, 16'h003E, 0);
        add(0, 0, 1, 5'd17, 16'h0000, 1, 16'h00FF, 0);
        add(0, 0, 1, 5'd30, 16'h0000, 1, 16'h0000, 0);
        add(0, 1, 0, 5'd5,  16'h00A5, 0, 16'h0000, 0);
        add(0, 0, 1, 5'd5,  16'h0000, 1, 16'h00A5, 0);
        add(0, 1, 1, 5'd5,  16'h003C, 0, 16'h00A5, 0);
        add(0, 0, 0, 5'd0,  16'h0000, 0, 16'h00A5, 0);
        add(0, 0, 1, 5'd5,  16'h0000, 1, 16'h003C, 0);
        add(0, 0, 1, 5'd4,  16'h0000, 1, 16'h001E, 0);
        add(1, 0, 1, 5'd0,  16'h0000, 1, 16'h0080, 0);
        add(1, 1, 0, 5'd25, 16'h0011, 0, 16'h0080, 1);
        add(1, 0, 1, 5'd25, 16'h0000, 1, 16'h0000, 1);
        add(1, 1, 0, 5'd19, 16'h0099, 0, 16'h0000, 0);
        add(1, 0, 1, 5'd19, 16'h0000, 1, 16'h0099, 0);
        add(1, 1, 0, 5'd20, 16'h0022, 0, 16'h0099, 1);
        add(1, 0, 1, 5'd20, 16'h0000, 1, 16'h0000, 1);
        add(2, 0, 1, 5'd0,  16'h0000, 1, 16'h0000, 0);
        add(2, 0, 1, 5'd17, 16'h0000, 1, 16'h0000, 0);
        add(2, 1, 0, 5'd7,  16'hBEEF, 0, 16'h0000, 0);
        add(2, 0, 1, 5'd7,  16'h0000, 1, 16'hBEEF, 0);
        add(2, 0, 1, 5'd31, 16'h0000, 1, 16'h0000, 0);
        add(0, 0, 1, 5'd25, 16'h0000, 1, 16'h0011, 0);

        foreach (tbl[i]) begin
            WE = tbl[i].we; RE = tbl[i].re; addr = tbl[i].a; din = tbl[i].d;
            step();
            WE = 1'b0; RE = 1'b0;
            case (tbl[i].sel)
                0:       begin a_rv = rv0; a_err = err0; a_d = {8'h00, dout0}; end
                1:       begin a_rv = rv1; a_err = err1; a_d = {8'h00, dout1}; end
                default: begin a_rv = rv2; a_err = err2; a_d = dout2; end
            endcase
            chk($sformatf("vec%0d_vld", i), 16'(a_rv), 16'(tbl[i].ev));
            chk($sformatf("vec%0d_err", i), 16'(a_err), 16'(tbl[i].ee));
            chk($sformatf("vec%0d_data", i), a_d, tbl[i].ed);
        end

        // Restart at init_cnt=10.
        do_init(10, 1'b0, bn, dn, vn);
        chk("restart_busy_cycles", 16'(bn), 16'd43);
        chk("restart_done_pulses", 16'(dn), 16'd1);

        // Reset aborting an init pass at init_cnt=8.
        WE = 1'b1; addr = 5'd3;  din = 16'h00C3; step();
        addr = 5'd20; din = 16'h0077; step();
        WE = 1'b0;
        Initialize = 1'b1; step();
        Initialize = 1'b0;
        repeat (8) step();
        chk("abort_busy_before", 16'(busy0), 16'd1);
        Reset = 1'b1; step();
        Reset = 1'b0;
        chk("abort_busy_after", 16'(busy0), 16'd0);
        chk("abort_done", 16'(done0), 16'd0);
        rd0("abort_w3", 5'd3, 8'h5A);
        rd0("abort_w7", 5'd7, 8'h63);
        rd0("abort_w20", 5'd20, 8'h77);

        // Requests held during Busy are ignored.
        do_init(0, 1'b1, bn, dn, vn);
        chk("hold_busy_cycles", 16'(bn), 16'd32);
        chk("hold_done_pulses", 16'(dn), 16'd1);
        chk("hold_no_strobes", 16'(vn), 16'd0);
        rd0("hold_w2", 5'd2, 8'h0C);
        chk("hold_w2_zero16", dout2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
